unified_mem_arbiter: RTL

Shares one single-ported, synchronous-read word memory between the instruction-fetch port and the data (load/store) port of the pipelined RISC-V core. This allows program and data to live in one array. Each cycle the block grants at most one requester, drives the memory, and routes the read data back one cycle later. Data accesses have priority, with a starvation bound that protects fetch. The pipeline uses `if_gnt` and `d_gnt` as its stall signals.

---
 rtl/unified_mem_arbiter_if.sv | 37 +++
 rtl/unified_mem_arbiter.sv | 91 +++++++++
 2 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Request, grant and memory-side bundle for the unified memory arbiter.
interface unified_mem_arbiter_if #(
    parameter int MEM_AW = 6
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one synchronous-read memory between fetch and data ports.
// Data wins unless fetch has been starved for STARVE_MAX cycles.
module unified_mem_arbiter #(
    parameter int MEM_AW     = 6,
    parameter int STARVE_MAX = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    unified_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {NONE, FETCH, DLOAD} owner_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    owner_t      owner;
    logic [3:0]  starve_cnt;
    logic [31:0] if_hold;
    logic [31:0] d_hold;
    logic        d_err_q;
    logic        d_ok;
    logic        force_f;
    logic        d_win;
    logic        f_win;

    logic unused_addr;
    assign unused_addr = ^{bus.if_addr[31:MEM_AW+2], bus.if_addr[1:0],
                           bus.d_addr[31:MEM_AW+2]};

    always_comb begin
        d_ok    = bus.d_req && (bus.d_addr[1:0] == 2'b00);
        force_f = bus.if_req && (starve_cnt == SMAX);
        d_win   = rst_n && d_ok && !force_f;
        f_win   = rst_n && bus.if_req && !d_win;
    end

    always_comb begin
        bus.if_gnt    = f_win;
        bus.d_gnt     = d_win;
        bus.mem_en    = d_win | f_win;
        bus.mem_we    = d_win & bus.d_we;
        bus.mem_be    = d_win ? bus.d_be : 4'h0;
        bus.mem_wdata = d_win ? bus.d_wdata : 32'h0;
        bus.mem_addr  = '0;
        if (d_win)
            bus.mem_addr = bus.d_addr[MEM_AW+1:2];
        else if (f_win)
            bus.mem_addr = bus.if_addr[MEM_AW+1:2];
    end

    // Read data passes straight through in the valid cycle and is held after.
    always_comb begin
        bus.if_rvalid = (owner == FETCH);
        bus.d_rvalid  = (owner == DLOAD);
        bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : if_hold;
        bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : d_hold;
        bus.d_err     = d_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= NONE;
            starve_cnt <= 4'h0;
            if_hold    <= 32'h0;
            d_hold     <= 32'h0;
            d_err_q    <= 1'b0;
        end else begin
            if (bus.if_req && !f_win)
                starve_cnt <= (starve_cnt == SMAX) ? starve_cnt
                                                   : starve_cnt + 4'h1;
            else
                starve_cnt <= 4'h0;

            if (d_win && !bus.d_we)
                owner <= DLOAD;
            else if (f_win)
                owner <= FETCH;
            else
                owner <= NONE;

            if (owner == FETCH)
                if_hold <= bus.mem_rdata;
            if (owner == DLOAD)
                d_hold <= bus.mem_rdata;

            if (!bus.d_req)
                d_err_q <= 1'b0;
            else if (bus.d_addr[1:0] != 2'b00)
                d_err_q <= 1'b1;
        end
    end
endmodule
